// File: rtl/p2s_framer_if.sv
// Word-in / serial-out bundle for p2s_framer: codeword handshake plus serial line status.
// The master side is the codeword source; the slave side is the framer.
interface p2s_framer_if #(
    parameter int DATA_W = 14
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              dout;
    logic              busy;
    logic              frame_done;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  dout,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output dout,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/p2s_framer.sv
// Parallel-to-serial framer: "11" preamble, codeword MSB first, then IDLE_GAP guard zeros.
// A one-word holding register lets the next codeword be accepted while a frame shifts out.
module p2s_framer #(
    parameter int DATA_W   = 14,
    parameter int IDLE_GAP = 2
) (
    input  logic         clk,
    input  logic         rst,
    p2s_framer_if.slave  bus
);
    localparam int MAX_CNT = (DATA_W > IDLE_GAP) ? DATA_W : IDLE_GAP;
    localparam int CNT_W   = $clog2(MAX_CNT);
    localparam logic [CNT_W-1:0] LAST_PRE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'(IDLE_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] hold_q;
    logic              hold_valid_q;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              dout_q;
    logic              busy_q;
    logic              frame_done_q;

    // Ready depends only on the holding register, never on din_valid.
    assign bus.din_ready  = ~hold_valid_q;
    assign bus.dout       = dout_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            dout_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    dout_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (hold_valid_q) begin
                        shift_q      <= hold_q;
                        hold_valid_q <= 1'b0;
                        dout_q       <= 1'b1;
                        busy_q       <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= PRE;
                    end
                end
                PRE: begin
                    dout_q <= 1'b1;
                    if (cnt_q == LAST_PRE) begin
                        dout_q  <= shift_q[DATA_W-1];
                        shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                        cnt_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_q == LAST_DATA) begin
                        dout_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= GAP;
                    end else begin
                        dout_q  <= shift_q[DATA_W-1];
                        shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                GAP: begin
                    dout_q <= 1'b0;
                    if (cnt_q == LAST_GAP) begin
                        cnt_q <= '0;
                        // A waiting word starts its preamble immediately, keeping frames gapless.
                        if (hold_valid_q) begin
                            shift_q      <= hold_q;
                            hold_valid_q <= 1'b0;
                            dout_q       <= 1'b1;
                            state_q      <= PRE;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    dout_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase

            // Accept only into an empty holding register; a transfer needs it full, so the two never collide.
            if (bus.din_valid && !hold_valid_q) begin
                hold_q       <= bus.din;
                hold_valid_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_p2s_framer.sv
// Bench for p2s_framer: frame-timeline reference model, serial receiver model, directed and random words.
// Each clock prints one line per handshake transaction accepted by the framer.
module tb_p2s_framer;
    localparam int W = 14;
    localparam int G = 2;
    localparam int P = 2 + W + G;

    logic clk;
    logic rst;

    p2s_framer_if #(.DATA_W(W)) bus ();

    p2s_framer #(.DATA_W(W), .IDLE_GAP(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: position inside the current frame (-1 when idle) plus the one-word hold.
    int            m_pos = -1;
    logic [W-1:0]  m_cur = '0;
    logic [W-1:0]  m_hold = '0;
    bit            m_hv = 1'b0;
    logic [W-1:0]  sent[$];

    // Receiver model: looks for "11", then takes the next W bits as a codeword.
    bit            rx_cap = 1'b0;
    int            rx_ones = 0;
    int            rx_cnt = 0;
    logic [W-1:0]  rx_word = '0;
    int            rx_frames = 0;

    logic [31:0]   hist = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit   hv_pre;
        logic e_dout;
        if (rst) begin
            m_pos   = -1;
            m_hv    = 1'b0;
            sent.delete();
            rx_cap  = 1'b0;
            rx_ones = 0;
            rx_cnt  = 0;
        end else begin
            hv_pre = m_hv;
            if (m_pos >= 0) begin
                m_pos++;
                if (m_pos == P) m_pos = -1;
            end
            if (m_pos == -1 && hv_pre) begin
                m_cur = m_hold;
                m_hv  = 1'b0;
                m_pos = 0;
            end
            if (!hv_pre && bus.din_valid) begin
                m_hold = bus.din;
                m_hv   = 1'b1;
                sent.push_back(bus.din);
                $display("t=%0t accept word %04h", $time, bus.din);
            end
        end

        @(posedge clk);
        #1;

        if (m_pos < 0)           e_dout = 1'b0;
        else if (m_pos < 2)      e_dout = 1'b1;
        else if (m_pos < 2 + W)  e_dout = m_cur[W-1-(m_pos-2)];
        else                     e_dout = 1'b0;

        check("dout",       {31'd0, bus.dout},       {31'd0, e_dout});
        check("busy",       {31'd0, bus.busy},       {31'd0, (m_pos >= 0)});
        check("frame_done", {31'd0, bus.frame_done}, {31'd0, (m_pos == 2 + W)});
        check("din_ready",  {31'd0, bus.din_ready},  {31'd0, !m_hv});

        hist = {hist[30:0], bus.dout};

        if (!rst) begin
            if (rx_cap) begin
                rx_word = {rx_word[W-2:0], bus.dout};
                rx_cnt++;
                if (rx_cnt == W) begin
                    rx_cap  = 1'b0;
                    rx_ones = 0;
                    rx_frames++;
                    check("rx_expected_word", {31'd0, (sent.size() != 0)}, 32'd1);
                    if (sent.size() != 0) check("rx_word", {18'd0, rx_word}, {18'd0, sent.pop_front()});
                end
            end else begin
                rx_ones = bus.dout ? rx_ones + 1 : 0;
                if (rx_ones == 2) begin
                    rx_cap = 1'b1;
                    rx_cnt = 0;
                end
            end
        end
    endtask

    // Offers a word and holds it until the framer takes it; din_valid drops afterwards.
    task automatic send(input logic [W-1:0] word);
        bit acc;
        acc = 1'b0;
        bus.din       = word;
        bus.din_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            acc = !m_hv;
            step();
            if (acc) break;
        end
        check("send_accepted", {31'd0, acc}, 32'd1);
        bus.din_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        bit hit;
        rst           = 1'b1;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        run(2);
        rst = 1'b0;
        run(2);

        // Single frame, then the two extreme codewords.
        send(14'h2D36);
        run(18);
        check("frame_2D36", {14'd0, hist[17:0]}, 32'h0003B4D8);
        run(2);
        send(14'h3FFF);
        run(18);
        check("frame_3FFF", {14'd0, hist[17:0]}, 32'h0003FFFC);
        run(2);
        send(14'h0000);
        run(18);
        check("frame_0000", {14'd0, hist[17:0]}, 32'h00030000);
        run(2);

        // Back-to-back: second word waits in the hold register, frames abut.
        send(14'h1555);
        send(14'h2AAA);
        run(40);

        // Backpressure: three words offered while the first is on the line.
        send(W'($urandom));
        send(W'($urandom));
        send(W'($urandom));
        run(60);
        check("bp_drained", sent.size(), 32'd0);

        // Reset during a data bit, then a clean frame.
        send(W'($urandom));
        hit = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (m_pos == 7) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        check("reached_data_bit5", {31'd0, hit}, 32'd1);
        send(W'($urandom));
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(3);
        send(14'h2D36);
        run(18);
        check("frame_after_rst", {14'd0, hist[17:0]}, 32'h0003B4D8);
        run(2);

        // Random loopback through the receiver model.
        rx_frames = 0;
        for (int n = 0; n < 100; n++) begin
            bus.din = W'($urandom);
            run($urandom_range(0, 3));
            send(W'($urandom));
        end
        run(45);
        check("loop_drained", sent.size(), 32'd0);
        check("loop_frames", rx_frames, 32'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/p2s_framer.md
Name: p2s_framer

Overview:
Parallel-to-serial transmitter that takes 14-bit Hamming codewords from the encoder and drives them onto a 1-bit serial line. Each word goes out as a frame: a "11" preamble, then the codeword MSB first, then a run of guard zeros. The block sits directly upstream of the serial-to-parallel receiver (S2P), which detects frames by the "11" preamble. It has a valid/ready input with a one-word holding register, so the next word can be accepted while the current frame shifts out.

Parameters:
DATA_W, 14, codeword width in bits (must be >= 2)
IDLE_GAP, 2, number of guard '0' bits after each frame (must be >= 1)

Ports:
clk  input  1  system clock (ps_clk domain); all logic is on its rising edge
rst  input  1  reset, synchronous, active-high
din  input  DATA_W  codeword to transmit
din_valid  input  1  din is valid this cycle
din_ready  output  1  holding register is empty; a word is accepted on any edge where din_valid && din_ready
dout  output  1  serial line, registered
busy  output  1  a frame (preamble, data or guard) is in progress
frame_done  output  1  one-cycle pulse after the last data bit of a frame

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - dout=0, busy=0, frame_done=0, din_ready=1.
  - FSM in IDLE, holding register empty, counters 0.
- Storage:
  - hold_reg[DATA_W-1:0] plus hold_valid.
  - shift_reg[DATA_W-1:0].
  - bit counter, sized for max(DATA_W, IDLE_GAP).
- din_ready = !hold_valid. It is combinational from the register only, with no path from din_valid.
- Accept edge: hold_reg <= din and hold_valid <= 1.
- FSM states: IDLE, PRE, DATA, GAP.
  - IDLE:
    - dout driven 0.
    - If hold_valid: shift_reg <= hold_reg, hold_valid <= 0, dout <= 1, go to PRE.
  - PRE:
    - Lasts 2 bit cycles; dout is 1 in both.
    - At the end of the 2nd cycle, dout <= shift_reg MSB and go to DATA.
  - DATA:
    - Lasts DATA_W cycles; dout carries shift_reg[DATA_W-1] down to [0], one bit per cycle (left shift).
    - After the last bit: dout <= 0, frame_done <= 1 for exactly one cycle, go to GAP.
  - GAP:
    - Lasts IDLE_GAP cycles with dout=0.
    - At the end: if hold_valid, load as in IDLE and go directly to PRE (dout <= 1); otherwise go to IDLE.
- Timing:
  - Latency from the accept edge (block idle) to the first preamble '1' on dout is 1 cycle.
  - Frame period is 2 + DATA_W + IDLE_GAP cycles (18 at defaults).
  - Back-to-back words produce gapless frames at exactly that period.
- busy: 1 in PRE, DATA and GAP; 0 in IDLE.
- Holding register behaviour:
  - It is freed on the same edge that loads shift_reg; din_ready rises the following cycle.
  - A new word can be accepted during any cycle of PRE, DATA or GAP.
  - Never accept and transfer on the same edge. This is guaranteed because din_ready=0 while hold_valid=1.
- din_valid while din_ready=0: ignored, no capture; the source must hold the word.
- Reset mid-frame: the frame is aborted with no frame_done pulse. dout is 0 from the next cycle and the held word is discarded.
- dout is never 1 outside PRE and DATA. The guard zeros keep the receiver from seeing a false preamble formed by trailing data bits.

Test Plan:
- Single frame: after reset, din=14'h2D36 with din_valid for 1 cycle -> dout from the next cycle = 1,1,1,0,1,1,0,1,0,0,1,1,0,1,1,0, then 0,0. busy=1 for 18 cycles. frame_done pulses in the cycle after the last data bit.
- Extremes:
  - din=14'h3FFF -> 16 consecutive 1s, then 2 zeros.
  - din=14'h0000 -> 1,1 followed by 16 zeros. frame_done still pulses.
- Back-to-back: din_valid held high with 14'h1555 then 14'h2AAA -> second word accepted during the first frame. Frames are exactly 18 cycles apart with 2 zeros between them. din_ready is low while hold is full and high the cycle after transfer.
- Backpressure: offer 3 words while the first is transmitting -> the third is not accepted until the second is loaded. The source holding din stable yields 3 correct frames in order, with no drop or duplicate.
- Reset mid-frame: assert rst during data bit 5 -> next cycle dout=0, busy=0, din_ready=1, no frame_done. A following word of 14'h2D36 transmits correctly.
- Loopback: dout into S2P, send 100 random codewords -> S2P's parallel codeword output matches every word in order.
